// File: rtl/falc56_pkg.sv
// Shared types and constants for the FALC56 bus responder.
package falc56_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WRITE,
      ST_READ,
      ST_CLEAR
   } state_t;

   localparam logic [7:0] ISR_ADDR_DEF = 8'h68;
   localparam logic [7:0] RST_VAL_DEF  = 8'h00;
   localparam int         SYNC_DEPTH   = 2;
   localparam int         NUM_BANKS    = 2;

   // Synchronized bus word layout: {ale, rd_n, wr_n, cs_n[1:0], badd[7:0]}
   localparam int         BUS_W        = 13;

endpackage

// File: rtl/falc56_bus_sync.sv
// Synchronizes the FALC56 bus pins into the clock domain and detects strobe edges.
module falc56_bus_sync
   import falc56_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ale,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [1:0] cs_n,
   input  logic [7:0] badd,
   output logic       rd_s,
   output logic       wr_s,
   output logic [1:0] cs_s,
   output logic [7:0] badd_s,
   output logic [7:0] badd_d,
   output logic       ale_fall,
   output logic       rd_fall,
   output logic       rd_rise,
   output logic       wr_fall,
   output logic       wr_rise
);

   localparam logic [BUS_W-1:0] BUS_IDLE = {1'b0, 1'b1, 1'b1, 2'b11, 8'h00};

   logic [SYNC_DEPTH*BUS_W-1:0] sr;
   logic [BUS_W-1:0]            cur;
   logic                        ale_q;
   logic                        rd_q;
   logic                        wr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr     <= {SYNC_DEPTH{BUS_IDLE}};
         ale_q  <= 1'b0;
         rd_q   <= 1'b1;
         wr_q   <= 1'b1;
         badd_d <= '0;
      end else begin
         sr     <= {sr[(SYNC_DEPTH-1)*BUS_W-1:0], ale, rd_n, wr_n, cs_n, badd};
         ale_q  <= cur[12];
         rd_q   <= cur[11];
         wr_q   <= cur[10];
         badd_d <= cur[7:0];
      end
   end

   assign cur      = sr[SYNC_DEPTH*BUS_W-1 -: BUS_W];
   assign rd_s     = cur[11];
   assign wr_s     = cur[10];
   assign cs_s     = cur[9:8];
   assign badd_s   = cur[7:0];
   assign ale_fall = ale_q & ~cur[12];
   assign rd_fall  = rd_q & ~cur[11];
   assign rd_rise  = ~rd_q & cur[11];
   assign wr_fall  = wr_q & ~cur[10];
   assign wr_rise  = ~wr_q & cur[10];

endmodule

// File: rtl/falc56_bus_responder.sv
// Target-side FALC56 bus model: two 256x8 register banks, read-to-clear ISR per bank,
// framer-reset bank clear and protocol error reporting.
module falc56_bus_responder
   import falc56_pkg::*;
#(
   parameter logic [7:0] ISR_ADDR = ISR_ADDR_DEF,
   parameter logic [7:0] RST_VAL  = RST_VAL_DEF
) (
   input  logic       PHY_CLK33_I,
   input  logic       PHY_RSTn_I,
   input  logic       F56_RSTn_I,
   input  logic [7:0] F56_BADD_I,
   output logic [7:0] F56_BADD_O,
   output logic       F56_BADD_DIR_O,
   input  logic       F56_ALE_I,
   input  logic       F56_RDn_I,
   input  logic       F56_WRn_I,
   input  logic [1:0] F56_CSn_I,
   output logic [1:0] F56_INT_O,
   input  logic [1:0] EVT_STB_I,
   input  logic [7:0] EVT_BITS_I,
   output logic       BUSY_O,
   output logic       ERR_O
);

   logic       rd_s, wr_s, ale_fall, rd_fall, rd_rise, wr_fall, wr_rise;
   logic [1:0] cs_s;
   logic [7:0] badd_s, badd_d;

   state_t     state_q, state_d;
   logic [7:0] addr_q, dout_q, clr_cnt;
   logic       bank_q, dir_q, err_q, err_hold, clr_done;
   logic       dir_d, err_d, hold_set, addr_ld, sel_ld, rd_commit, wr_commit;
   logic       cs_one, cs_idx, rd_bank;
   logic [7:0] rd_data;
   logic [7:0] rd_word [NUM_BANKS];
   logic [7:0] isr_w   [NUM_BANKS];

   falc56_bus_sync u_sync (
      .clk      (PHY_CLK33_I),
      .rst_n    (PHY_RSTn_I),
      .ale      (F56_ALE_I),
      .rd_n     (F56_RDn_I),
      .wr_n     (F56_WRn_I),
      .cs_n     (F56_CSn_I),
      .badd     (F56_BADD_I),
      .rd_s     (rd_s),
      .wr_s     (wr_s),
      .cs_s     (cs_s),
      .badd_s   (badd_s),
      .badd_d   (badd_d),
      .ale_fall (ale_fall),
      .rd_fall  (rd_fall),
      .rd_rise  (rd_rise),
      .wr_fall  (wr_fall),
      .wr_rise  (wr_rise)
   );

   assign cs_one  = (cs_s == 2'b10) || (cs_s == 2'b01);
   assign cs_idx  = ~cs_s[1];
   assign rd_bank = (state_q == ST_READ) ? bank_q : cs_idx;
   assign rd_data = (addr_q == ISR_ADDR) ? isr_w[rd_bank] : rd_word[rd_bank];

   // err_hold blocks re-entry into an access until both strobes have released,
   // so one bad strobe yields exactly one error pulse and no access.
   always_comb begin
      state_d   = state_q;
      dir_d     = 1'b0;
      err_d     = 1'b0;
      hold_set  = 1'b0;
      addr_ld   = 1'b0;
      sel_ld    = 1'b0;
      rd_commit = 1'b0;
      wr_commit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ale_fall) begin
               state_d = ST_ADDR;
               addr_ld = 1'b1;
            end
         end
         ST_ADDR: begin
            addr_ld = ale_fall;
            if ((!rd_s || !wr_s) && !err_hold) begin
               if ((!rd_s && !wr_s) || cs_s == 2'b00) begin
                  err_d    = 1'b1;
                  hold_set = 1'b1;
               end else if (cs_one) begin
                  sel_ld = 1'b1;
                  if (!wr_s) begin
                     state_d = ST_WRITE;
                  end else begin
                     state_d = ST_READ;
                     dir_d   = 1'b1;
                  end
               end
            end
         end
         ST_WRITE: begin
            if (!rd_s || cs_s == 2'b00) begin
               err_d    = 1'b1;
               hold_set = 1'b1;
               state_d  = ST_ADDR;
            end else if (wr_rise) begin
               wr_commit = 1'b1;
               state_d   = ST_ADDR;
            end
         end
         ST_READ: begin
            if (!wr_s || cs_s == 2'b00) begin
               err_d    = 1'b1;
               hold_set = 1'b1;
               state_d  = ST_ADDR;
            end else if (rd_rise) begin
               rd_commit = 1'b1;
               state_d   = ST_ADDR;
            end else begin
               dir_d = 1'b1;
            end
         end
         ST_CLEAR: begin
            err_d = rd_fall | wr_fall;
            if (F56_RSTn_I && (clr_done || clr_cnt == 8'hFF)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (!F56_RSTn_I) begin
         state_d   = ST_CLEAR;
         dir_d     = 1'b0;
         hold_set  = 1'b0;
         addr_ld   = 1'b0;
         sel_ld    = 1'b0;
         rd_commit = 1'b0;
         wr_commit = 1'b0;
         if (state_q != ST_CLEAR) err_d = 1'b0;
      end
   end

   always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
      if (!PHY_RSTn_I) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         bank_q   <= 1'b0;
         dir_q    <= 1'b0;
         dout_q   <= '0;
         err_q    <= 1'b0;
         err_hold <= 1'b0;
         clr_cnt  <= '0;
         clr_done <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
         dout_q  <= dir_d ? rd_data : '0;
         if (addr_ld) addr_q <= badd_s;
         if (sel_ld)  bank_q <= cs_idx;
         if (hold_set)         err_hold <= 1'b1;
         else if (rd_s && wr_s) err_hold <= 1'b0;
         if (state_q == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 8'd1;
            if (clr_cnt == 8'hFF) clr_done <= 1'b1;
         end else begin
            clr_cnt  <= '0;
            clr_done <= 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      localparam logic BANK_ID = 1'(g);

      logic [7:0] mem [256];
      logic       we, isr_hit, int_q;
      logic [7:0] wa, wd, isr_q, isr_d;

      always_comb begin
         we = 1'b0;
         wa = addr_q;
         wd = badd_d;
         if (state_q == ST_CLEAR) begin
            we = 1'b1;
            wa = clr_cnt;
            wd = RST_VAL;
         end else if (wr_commit && bank_q == BANK_ID) begin
            we = 1'b1;
         end
      end

      always_ff @(posedge PHY_CLK33_I) begin
         if (we) mem[wa] <= wd;
      end

      assign isr_hit = (bank_q == BANK_ID) && (addr_q == ISR_ADDR);

      // Clear/overwrite resolves first, then events OR in on top.
      always_comb begin
         isr_d = isr_q;
         if (state_q == ST_CLEAR)          isr_d = RST_VAL;
         else if (isr_hit && wr_commit)    isr_d = badd_d;
         else if (isr_hit && rd_commit)    isr_d = '0;
         if (EVT_STB_I[g]) isr_d = isr_d | EVT_BITS_I;
      end

      always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
         if (!PHY_RSTn_I) begin
            isr_q <= '0;
            int_q <= 1'b1;
         end else begin
            isr_q <= isr_d;
            int_q <= (isr_q == '0);
         end
      end

      assign rd_word[g]   = mem[addr_q];
      assign isr_w[g]     = isr_q;
      assign F56_INT_O[g] = int_q;
   end

   assign F56_BADD_O     = dout_q;
   assign F56_BADD_DIR_O = dir_q;
   assign ERR_O          = err_q;
   assign BUSY_O         = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_falc56_bus_responder.sv
// Directed bench for falc56_bus_responder with a read-data scoreboard checked by a monitor.
module tb_falc56_bus_responder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       f56_rstn;
   logic [7:0] badd_in;
   logic [7:0] badd_out;
   logic       dir;
   logic       ale, rdn, wrn;
   logic [1:0] csn;
   logic [1:0] irq_n;
   logic [1:0] evt_stb;
   logic [7:0] evt_bits;
   logic       busy, err;

   always #5 clk = ~clk;

   falc56_bus_responder #(
      .ISR_ADDR (8'h68),
      .RST_VAL  (8'h00)
   ) dut (
      .PHY_CLK33_I    (clk),
      .PHY_RSTn_I     (rst_n),
      .F56_RSTn_I     (f56_rstn),
      .F56_BADD_I     (badd_in),
      .F56_BADD_O     (badd_out),
      .F56_BADD_DIR_O (dir),
      .F56_ALE_I      (ale),
      .F56_RDn_I      (rdn),
      .F56_WRn_I      (wrn),
      .F56_CSn_I      (csn),
      .F56_INT_O      (irq_n),
      .EVT_STB_I      (evt_stb),
      .EVT_BITS_I     (evt_bits),
      .BUSY_O         (busy),
      .ERR_O          (err)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         rd_cyc  = 0;
   int         err_cnt = 0;
   int         busy_cycles = 0;
   logic       dir_prev = 1'b0;
   logic       err_prev = 1'b0;
   logic [7:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the responder starts driving the bus.
   always @(negedge clk) begin
      if (dir && !dir_prev) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_unexpected: got 0x%0h, expected no read (t=%0t)", badd_out, $time);
         end else begin
            check("read_data", 32'(badd_out), 32'(exp_q.pop_front()));
            check("read_latency", 32'(cyc - rd_cyc), 32'd3);
         end
      end
      if (err) begin
         err_cnt++;
         check("err_width", 32'(err_prev), 32'd0);
      end
      if (busy) busy_cycles++;
      dir_prev = dir;
      err_prev = err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_addr(input logic [7:0] a);
      badd_in = a;
      ale = 1'b1;
      tick(4);
      ale = 1'b0;
      tick(4);
   endtask

   task automatic bus_write(input logic [1:0] cs, input logic [7:0] d);
      csn = cs;
      badd_in = d;
      tick(4);
      wrn = 1'b0;
      tick(4);
      wrn = 1'b1;
      tick(4);
      csn = 2'b11;
      tick(1);
   endtask

   task automatic bus_read(input logic [1:0] cs, input logic [7:0] exp,
                           input bit inj = 1'b0, input logic [7:0] inj_bits = 8'h00);
      exp_q.push_back(exp);
      csn = cs;
      tick(4);
      rdn = 1'b0;
      rd_cyc = cyc;
      tick(5);
      rdn = 1'b1;
      tick(2);
      check("rd_hold", 32'(dir), 32'd1);
      if (inj) begin
         evt_stb  = 2'b01;
         evt_bits = inj_bits;
      end
      tick(1);
      evt_stb = 2'b00;
      check("rd_release", 32'(dir), 32'd0);
      csn = 2'b11;
      tick(4);
   endtask

   task automatic wait_clear_done();
      int n = 0;
      while (busy && n < 400) begin
         tick(1);
         n++;
      end
      check("clear_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e0;
      rst_n = 1'b0; f56_rstn = 1'b1; badd_in = 8'h00;
      ale = 1'b0; rdn = 1'b1; wrn = 1'b1; csn = 2'b11;
      evt_stb = 2'b00; evt_bits = 8'h00;
      tick(3);
      check("rst_badd_o", 32'(badd_out), 32'h00);
      check("rst_dir", 32'(dir), 32'd0);
      check("rst_int", 32'(irq_n), 32'h3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick(3);

      // Framer reset to define bank contents
      busy_cycles = 0;
      f56_rstn = 1'b0;
      tick(1);
      f56_rstn = 1'b1;
      check("clear_busy", 32'(busy), 32'd1);
      wait_clear_done();
      check("clear_len", 32'(busy_cycles), 32'd256);
      check("clear_no_err", 32'(err_cnt), 32'd0);

      // Write then read back, bank isolation, address reuse
      bus_addr(8'h12);
      bus_write(2'b10, 8'h5A);
      bus_read(2'b10, 8'h5A);
      bus_write(2'b01, 8'hA5);
      bus_read(2'b10, 8'h5A);
      bus_read(2'b01, 8'hA5);
      bus_addr(8'h33);
      bus_read(2'b01, 8'h00);

      // Interrupt set and read-to-clear
      evt_stb = 2'b01; evt_bits = 8'h04;
      tick(1);
      evt_stb = 2'b00;
      check("int_not_early", 32'(irq_n), 32'h3);
      tick(1);
      check("int_set", 32'(irq_n), 32'h2);
      bus_addr(8'h68);
      bus_read(2'b10, 8'h04);
      check("int_cleared", 32'(irq_n), 32'h3);
      bus_read(2'b10, 8'h00);

      // Event coincident with the read-to-clear commit
      evt_stb = 2'b01; evt_bits = 8'h01;
      tick(1);
      evt_stb = 2'b00;
      tick(3);
      check("int_set2", 32'(irq_n), 32'h2);
      bus_read(2'b10, 8'h01, 1'b1, 8'h80);
      check("int_stays_low", 32'(irq_n), 32'h2);
      bus_read(2'b10, 8'h80);
      check("int_released", 32'(irq_n), 32'h3);

      // Bus write overwrites bank1 ISR
      bus_write(2'b01, 8'h3C);
      check("int_from_write", 32'(irq_n), 32'h1);
      bus_read(2'b01, 8'h3C);
      check("int_after_wr_clr", 32'(irq_n), 32'h3);

      // Both chip selects low during a write
      e0 = err_cnt;
      bus_addr(8'h12);
      bus_write(2'b00, 8'hFF);
      check("err_dual_cs", 32'(err_cnt - e0), 32'd1);
      bus_read(2'b10, 8'h5A);
      bus_read(2'b01, 8'hA5);

      // RDn and WRn low together
      e0 = err_cnt;
      csn = 2'b10;
      tick(4);
      rdn = 1'b0; wrn = 1'b0;
      tick(5);
      rdn = 1'b1; wrn = 1'b1;
      tick(4);
      csn = 2'b11;
      tick(2);
      check("err_rd_wr", 32'(err_cnt - e0), 32'd1);
      bus_read(2'b10, 8'h5A);

      // Framer reset in the middle of a read
      exp_q.push_back(8'h5A);
      csn = 2'b10;
      tick(4);
      rdn = 1'b0;
      rd_cyc = cyc;
      tick(4);
      check("pre_reset_dir", 32'(dir), 32'd1);
      e0 = err_cnt;
      busy_cycles = 0;
      f56_rstn = 1'b0;
      tick(1);
      check("reset_dir_drop", 32'(dir), 32'd0);
      check("reset_busy", 32'(busy), 32'd1);
      f56_rstn = 1'b1;
      rdn = 1'b1;
      csn = 2'b11;
      tick(10);
      rdn = 1'b0;
      tick(5);
      rdn = 1'b1;
      wait_clear_done();
      check("clear_len2", 32'(busy_cycles), 32'd256);
      check("err_in_clear", 32'(err_cnt - e0), 32'd1);
      check("int_after_clear", 32'(irq_n), 32'h3);

      for (int a = 0; a < 256; a++) begin
         bus_addr(8'(a));
         bus_read(2'b10, 8'h00);
         bus_read(2'b01, 8'h00);
      end

      tick(4);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
